// File: rtl/shifter_pkg.sv
// Shared definitions for the multi-mode shifter pipeline.
// Holds the operation encoding (mode_t) and named constants for each
// encoding. Modes 3'b110 and 3'b111 are not enumerated; the datapath
// treats them like MODE_PASS.
package shifter_pkg;

  typedef enum logic [2:0] {
    MODE_LSL  = 3'b000,
    MODE_LSR  = 3'b001,
    MODE_ASR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_PASS = 3'b101
  } mode_t;

  localparam logic [2:0] MODE_ENC_LSL  = 3'b000;
  localparam logic [2:0] MODE_ENC_LSR  = 3'b001;
  localparam logic [2:0] MODE_ENC_ASR  = 3'b010;
  localparam logic [2:0] MODE_ENC_ROL  = 3'b011;
  localparam logic [2:0] MODE_ENC_ROR  = 3'b100;
  localparam logic [2:0] MODE_ENC_PASS = 3'b101;

endpackage

// File: rtl/shifter_stage.sv
// One stage of the logarithmic shifter pipeline.
// The stage shifts or rotates its word by the fixed distance D when bit 0
// of the amount it receives is set, otherwise it passes the word through.
// It registers the resulting word, the mode, the remaining amount bits
// (shifted down by one, so the next stage again looks at bit 0) and the
// valid bit. All registers load together when en is high.
//
// Configuration macro: SHIFTER_ROTATE_EN. When undefined, ROL acts as LSL,
// ROR acts as LSR and no rotate datapath exists.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   en              pipeline advance enable
//   valid_i/_o      stage valid in / registered valid out
//   data_i/_o       word in / registered shifted word out
//   mode_i/_o       operation in / registered operation out
//   amt_i/_o        remaining amount bits in / registered (amt_i >> 1) out
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int W  = 8,
  parameter int D  = 1,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          valid_i,
  input  logic [W-1:0]  data_i,
  input  mode_t         mode_i,
  input  logic [AW-1:0] amt_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output mode_t         mode_o,
  output logic [AW-1:0] amt_o
);

  logic          valid_q;
  logic [W-1:0]  data_q, data_d;
  mode_t         mode_q;
  logic [AW-1:0] amt_q;

  always_comb begin
    data_d = data_i;
    if (amt_i[0]) begin
      case (mode_i)
        MODE_LSL: data_d = data_i << D;
        MODE_LSR: data_d = data_i >> D;
        MODE_ASR: data_d = $signed(data_i) >>> D;
`ifdef SHIFTER_ROTATE_EN
        MODE_ROL: data_d = {data_i[W-D-1:0], data_i[W-1:W-D]};
        MODE_ROR: data_d = {data_i[D-1:0], data_i[W-1:D]};
`else
        MODE_ROL: data_d = data_i << D;
        MODE_ROR: data_d = data_i >> D;
`endif
        default:  data_d = data_i;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= MODE_LSL;
      amt_q   <= '0;
    end else if (en) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      mode_q  <= mode_i;
      amt_q   <= amt_i >> 1;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign mode_o  = mode_q;
  assign amt_o   = amt_q;

endmodule

// File: rtl/multi_mode_shifter_pipe.sv
// Pipelined multi-mode barrel shifter (LSL, LSR, ASR, ROL, ROR, pass).
// N registered stages; stage k moves the word by 2**k when amt[k] is set,
// so a word accepted at edge t is on y after edge t+N-1.
//
// Handshake: a transfer happens on a side when its valid and ready are both
// high at a rising edge. The whole pipeline advances when
// en = !out_valid || out_ready, and in_ready is exactly en, so a stalled
// output freezes every stage (y, y_zero, out_valid stay stable) and a
// simultaneous input and output transfer both complete. Cycles with en high
// and in_valid low insert a bubble.
//
// Configuration macro: SHIFTER_ROTATE_EN enables the rotate modes; without
// it ROL behaves as LSL and ROR as LSR. Ports and latency are unchanged.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   a, amt, mode        operand, shift amount (0..W-1), operation
//   out_valid/out_ready output handshake
//   y, y_zero           result and (y == 0) qualified by out_valid
module multi_mode_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2**N-1:0] a,
  input  logic [N-1:0]    amt,
  input  mode_t           mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2**N-1:0] y,
  output logic            y_zero
);

  localparam int W = 2 ** N;

  logic         en;
  logic         v_s  [0:N];
  logic [W-1:0] d_s  [0:N];
  mode_t        m_s  [0:N];
  logic [N-1:0] am_s [0:N];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign v_s[0]  = in_valid;
  assign d_s[0]  = a;
  assign m_s[0]  = mode;
  assign am_s[0] = amt;

  for (genvar k = 0; k < N; k++) begin : g_stage
    shifter_stage #(
      .W  (W),
      .D  (2 ** k),
      .AW (N)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .valid_i (v_s[k]),
      .data_i  (d_s[k]),
      .mode_i  (m_s[k]),
      .amt_i   (am_s[k]),
      .valid_o (v_s[k+1]),
      .data_o  (d_s[k+1]),
      .mode_o  (m_s[k+1]),
      .amt_o   (am_s[k+1])
    );
  end

  assign out_valid = v_s[N];
  assign y         = d_s[N];
  assign y_zero    = out_valid && (y == '0);

endmodule

// File: tb/tb_multi_mode_shifter_pipe.sv
module tb_multi_mode_shifter_pipe;
  import shifter_pkg::*;

  localparam int N = 3;
  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, y_zero;
  logic [W-1:0] a, y;
  logic [N-1:0] amt;
  mode_t        mode;

  multi_mode_shifter_pipe #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .amt       (amt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_zero    (y_zero)
  );

  int total = 0;
  int bad   = 0;
  int out_cnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // reference model: plain arithmetic over the whole shift amount
  function automatic logic [W-1:0] ref_model(input logic [W-1:0] x, input int s, input logic [2:0] m);
    logic [2*W-1:0] dbl;
    logic [W-1:0]   r;
    dbl = {x, x};
    case (m)
      3'd0: r = x << s;
      3'd1: r = x >> s;
      3'd2: r = W'($signed(x) >>> s);
`ifdef SHIFTER_ROTATE_EN
      3'd3: begin dbl = dbl << s; r = dbl[2*W-1:W]; end
      3'd4: begin dbl = dbl >> s; r = dbl[W-1:0]; end
`else
      3'd3: r = x << s;
      3'd4: r = x >> s;
`endif
      default: r = x;
    endcase
    return r;
  endfunction

  // scoreboard, sampled on the falling edge ahead of each active edge
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_y;
  logic         prev_z;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_is_en", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid) check("y_zero", 32'(y_zero), 32'(y == '0));
      else           check("y_zero_idle", 32'(y_zero), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_y", 32'(y), 32'(prev_y));
        check("stall_zero", 32'(y_zero), 32'(prev_z));
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) check("unexpected_output", 32'(y), 32'hDEAD);
        else check("sb_y", 32'(y), 32'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(a, int'(amt), mode));
      prev_stall = out_valid && !out_ready;
      prev_y = y;
      prev_z = y_zero;
    end
  end

  // driver: apply inputs, then advance to just after the next active edge
  task automatic cyc(input logic iv, input logic [W-1:0] ia, input logic [N-1:0] iamt,
                     input logic [2:0] imode, input logic ordy);
    in_valid  = iv;
    a         = ia;
    amt       = iamt;
    mode      = mode_t'(imode);
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [N-1:0] amt;
    logic [2:0]   mode;
    logic [W-1:0] exp_y;
    logic         exp_z;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int cnt;
    int base;
    logic [W-1:0] held;

    vecs[0]  = '{8'h96, 3'd3, 3'b000, 8'hB0, 1'b0};
    vecs[1]  = '{8'h96, 3'd3, 3'b001, 8'h12, 1'b0};
    vecs[2]  = '{8'h96, 3'd3, 3'b010, 8'hF2, 1'b0};
`ifdef SHIFTER_ROTATE_EN
    vecs[3]  = '{8'h96, 3'd3, 3'b011, 8'hB4, 1'b0};
    vecs[4]  = '{8'h96, 3'd3, 3'b100, 8'hD2, 1'b0};
`else
    vecs[3]  = '{8'h96, 3'd3, 3'b011, 8'hB0, 1'b0};
    vecs[4]  = '{8'h96, 3'd3, 3'b100, 8'h12, 1'b0};
`endif
    vecs[5]  = '{8'h96, 3'd3, 3'b101, 8'h96, 1'b0};
    vecs[6]  = '{8'h01, 3'd7, 3'b000, 8'h80, 1'b0};
    vecs[7]  = '{8'h80, 3'd7, 3'b001, 8'h01, 1'b0};
    vecs[8]  = '{8'h80, 3'd7, 3'b010, 8'hFF, 1'b0};
    vecs[9]  = '{8'h00, 3'd5, 3'b000, 8'h00, 1'b1};
    vecs[10] = '{8'h5A, 3'd0, 3'b010, 8'h5A, 1'b0};
    vecs[11] = '{8'hC3, 3'd0, 3'b100, 8'hC3, 1'b0};
    vecs[12] = '{8'h3C, 3'd6, 3'b110, 8'h3C, 1'b0};
    vecs[13] = '{8'h81, 3'd1, 3'b001, 8'h40, 1'b0};

    // reset
    reset = 1'b1;
    in_valid = 1'b0; a = '0; amt = '0; mode = MODE_LSL; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_y_zero", 32'(y_zero), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // table: single word, latency and value
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, vecs[i].a, vecs[i].amt, vecs[i].mode, 1'b1);
      cnt = 1;
      while (!out_valid && cnt < 10) begin
        cyc(1'b0, '0, '0, 3'd0, 1'b1);
        cnt++;
      end
      check($sformatf("vec%0d_latency", i), 32'(cnt), 32'(N));
      check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].exp_y));
      check($sformatf("vec%0d_zero", i), 32'(y_zero), 32'(vecs[i].exp_z));
      cyc(1'b0, '0, '0, 3'd0, 1'b1);
    end

    // back-to-back stream of 8 words
    base = out_cnt;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(i * 37 + 5), 3'(i), 3'(i % 6), 1'b1);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (i >= N - 1) check("stream_out_valid", 32'(out_valid), 32'd1);
    end
    for (int i = 0; i < N - 1; i++) begin
      check("stream_tail_valid", 32'(out_valid), 32'd1);
      cyc(1'b0, '0, '0, 3'd0, 1'b1);
    end
    cyc(1'b0, '0, '0, 3'd0, 1'b1);
    check("stream_count", 32'(out_cnt - base), 32'd8);

    // backpressure: fill, stall 5 cycles, drain
    base = out_cnt;
    cyc(1'b1, 8'h11, 3'd1, 3'd0, 1'b0);
    cyc(1'b1, 8'h22, 3'd2, 3'd1, 1'b0);
    cyc(1'b1, 8'h83, 3'd3, 3'd2, 1'b0);
    check("bp_full_valid", 32'(out_valid), 32'd1);
    held = y;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'hEE, 3'd1, 3'd0, 1'b0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_y_hold", 32'(y), 32'(held));
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, '0, 3'd0, 1'b1);
    check("bp_drain_count", 32'(out_cnt - base), 32'd3);

    // reset with two words in flight
    base = out_cnt;
    cyc(1'b1, 8'h77, 3'd1, 3'd0, 1'b1);
    cyc(1'b1, 8'h66, 3'd2, 3'd1, 1'b1);
    reset = 1'b1;
    cyc(1'b0, '0, '0, 3'd0, 1'b1);
    reset = 1'b0;
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, '0, 3'd0, 1'b1);
    check("rst2_no_output", 32'(out_cnt - base), 32'd0);

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 20) begin
      cyc(1'b0, '0, '0, 3'd0, 1'b1);
      cnt++;
    end
    check("random_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_mode_shifter_pipe.md
MULTI_MODE_SHIFTER_PIPE -- requirements
Module: multi_mode_shifter_pipe

Interface
REQ-001 SHALL have parameter N, default 3, log2 of the data width; data width W = 2**N; N SHALL be at least 1.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning the input word is presented.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the block accepts the input word this cycle.
REQ-006 SHALL have port a, input, W bits, the operand.
REQ-007 SHALL have port amt, input, N bits, the shift amount, 0..W-1.
REQ-008 SHALL have port mode, input, 3 bits, of type mode_t from shifter_pkg.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning y is valid.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts y.
REQ-011 SHALL have port y, output, W bits, the result.
REQ-012 SHALL have port y_zero, output, 1 bit, high when y equals 0, qualified by out_valid.

Function
REQ-013 SHALL implement these modes: 3'b000 LSL (logical shift left, zero fill); 3'b001 LSR (logical shift right, zero fill); 3'b010 ASR (arithmetic shift right, fill with a[W-1]); 3'b011 ROL; 3'b100 ROR; 3'b101 to 3'b111 pass a through unchanged.
REQ-014 SHALL compute the result with N registered stages; stage k (k = 0..N-1) SHALL shift or rotate by 2**k when amt[k] is 1, and pass the word unchanged when amt[k] is 0.
REQ-015 Each stage SHALL register its data, its mode, the remaining amt bits and a valid bit.
REQ-016 A transfer SHALL occur on the input when in_valid and in_ready are both 1, and on the output when out_valid and out_ready are both 1.
REQ-017 The pipeline enable SHALL be en = !out_valid || out_ready.
REQ-018 All stages SHALL advance together when en is 1 and hold all contents when en is 0.
REQ-019 in_ready SHALL equal en.
REQ-020 A word accepted at edge t SHALL appear with out_valid = 1 after edge t+N-1, i.e. N cycles later, when there is no backpressure.
REQ-021 When en is 1 and in_valid is 0, a bubble (valid = 0) SHALL enter stage 0.
REQ-022 Full throughput SHALL be one word per cycle, with no word lost or duplicated under any pattern of in_valid and out_ready.
REQ-023 While out_valid is 1 and out_ready is 0, the values of y, y_zero and out_valid SHALL remain stable.
REQ-024 amt = 0 SHALL return a unchanged in every mode.
REQ-025 amt = W-1 SHALL be legal in every mode; shifting by W or more is not representable.
REQ-026 When transfers occur on the input and the output in the same cycle, both SHALL complete.

Reset
REQ-027 When reset is 1 at a clock edge, every stage valid bit SHALL be cleared, out_valid SHALL be 0, and y and y_zero SHALL be 0.
REQ-028 Words in flight when reset is asserted SHALL be discarded and SHALL never appear on the output.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-030 Macro SHIFTER_ROTATE_EN SHALL control the rotate modes.
REQ-031 With SHIFTER_ROTATE_EN defined, ROL and ROR SHALL behave as in REQ-013.
REQ-032 Without SHIFTER_ROTATE_EN, mode 3'b011 SHALL behave as LSL and mode 3'b100 SHALL behave as LSR, and no rotate logic SHALL be synthesised.
REQ-033 Ports and latency SHALL be identical with and without SHIFTER_ROTATE_EN.

Structure
REQ-034 Package shifter_pkg SHALL hold the mode_t enum (MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROL, MODE_ROR, MODE_PASS) and the mode encoding constants.
REQ-035 Sub-module shifter_stage SHALL implement one stage, parametrised by W and the shift distance D = 2**k.
REQ-036 The top level SHALL instantiate N copies of shifter_stage with a generate loop.

Verification (N=3, a = 8'h96)
REQ-037 For each mode with amt = 3, no backpressure: LSL -> 8'hB0, LSR -> 8'h12, ASR -> 8'hF2, ROL -> 8'hB4, ROR -> 8'hD2, mode 3'b101 -> 8'h96; each result SHALL appear 3 cycles after acceptance.
REQ-038 Without SHIFTER_ROTATE_EN, ROL with amt 3 -> 8'hB0 and ROR with amt 3 -> 8'h12.
REQ-039 Back-to-back stream of 8 words with out_ready = 1 -> 8 results in order on consecutive cycles, in_ready held at 1.
REQ-040 Hold out_ready = 0 for 5 cycles with the pipeline full -> in_ready = 0, y stable; release -> all 3 words drain in order with none lost.
REQ-041 a = 8'h01, LSL, amt 7 -> y = 8'h80, y_zero = 0; a = 8'h80, LSR, amt 7 -> y = 8'h01; a = 8'h80, ASR, amt 7 -> y = 8'hFF; a = 8'h00 -> y_zero = 1.
REQ-042 Assert reset for 1 cycle with 2 words in flight -> out_valid = 0 next cycle, neither word ever emerges, and in_ready = 1.
